fracturable_mult_pipe: RTL and testbench

// - Parametrised, pipelined fracturable multiplier for the PIR-DSP datapath, built from NA*NB SUB_W x SUB_W sub-multipliers.
// - Mode 0: one (NA*SUB_W) x (NB*SUB_W) product.
// - Mode 1: NB independent lanes; each lane is the sum of NA SUB_W x SUB_W products (dot product).
// - Valid/ready streaming handshake with backpressure. Optional per-lane accumulator.

---
 rtl/fracturable_mult_pipe.sv | 229 ++++++++++++++++++++++
 tb/tb_fracturable_mult_pipe.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fracturable_mult_pipe.sv
// rtl/fracturable_mult_pipe.sv - pipelined fracturable multiplier: one wide product or NB-lane dot products
// Optional feature macro: FRAC_MULT_ACCUM_EN adds the acc port and per-lane accumulation.
module fracturable_mult_pipe #(
   parameter int  SUB_W  = 9,
   parameter int  NA     = 3,
   parameter int  NB     = 2,
   localparam int IN_W   = NA * NB * SUB_W,
   localparam int LANE_W = (NA + NB) * SUB_W,
   localparam int OUT_W  = NB * LANE_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IN_W-1:0]   a,
   input  logic [IN_W-1:0]   b,
   input  logic              a_sign,
   input  logic              b_sign,
   input  logic              mode,
`ifdef FRAC_MULT_ACCUM_EN
   input  logic              acc,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  result
);

   localparam int NP   = NA * NB;
   // each sub-multiplier sees SUB_W+1 bit operands (extension bit chooses signedness)
   localparam int PP_W = 2 * SUB_W + 2;

   // whole pipeline moves together; it freezes only while a result is held
   logic advance;

   // stage 1: captured beat
   logic              s1_valid_q, s1_valid_d;
   logic [IN_W-1:0]   s1_a_q, s1_a_d;
   logic [IN_W-1:0]   s1_b_q, s1_b_d;
   logic              s1_a_sign_q, s1_a_sign_d;
   logic              s1_b_sign_q, s1_b_sign_d;
   logic              s1_mode_q, s1_mode_d;

   // stage 2: partial products
   logic                       s2_valid_q, s2_valid_d;
   logic [NP-1:0][PP_W-1:0]    s2_pp_q, s2_pp_d;
   logic                       s2_mode_q, s2_mode_d;

`ifdef FRAC_MULT_ACCUM_EN
   logic              s1_acc_q, s1_acc_d;
   logic              s2_acc_q, s2_acc_d;
`endif

   // stage 3: output register
   logic              out_valid_q, out_valid_d;
   logic [OUT_W-1:0]  result_q, result_d;

   // sub-multiplier operands and products (combinational, from stage 1)
   logic [NP-1:0][SUB_W:0]     op_a, op_b;
   logic [NP-1:0][PP_W-1:0]    pp;

   // stage 3 combining network
   logic [LANE_W-1:0]             full_sum;
   logic [NB-1:0][LANE_W-1:0]     lane_sum;
   logic [NB-1:0][LANE_W-1:0]     lane_new;
   logic [NB-1:0][LANE_W-1:0]     lane_base;

   assign advance   = ~out_valid_q | out_ready;
   assign in_ready  = advance;
   assign out_valid = out_valid_q;
   assign result    = result_q;

   // stage 1 next state: capture the offered beat whenever the pipe moves
   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_a_d      = s1_a_q;
      s1_b_d      = s1_b_q;
      s1_a_sign_d = s1_a_sign_q;
      s1_b_sign_d = s1_b_sign_q;
      s1_mode_d   = s1_mode_q;
`ifdef FRAC_MULT_ACCUM_EN
      s1_acc_d    = s1_acc_q;
`endif
      if (advance) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_a_d      = a;
            s1_b_d      = b;
            s1_a_sign_d = a_sign;
            s1_b_sign_d = b_sign;
            s1_mode_d   = mode;
`ifdef FRAC_MULT_ACCUM_EN
            s1_acc_d    = acc;
`endif
         end
      end
   end

   // operand routing: sub-multiplier p = j*NA + i takes A chunk i / B chunk j in full mode,
   // and element p of both operands in lane mode (lane p/NA, element p%NA)
   always_comb begin
      op_a = '0;
      op_b = '0;
      for (int p = 0; p < NP; p++) begin
         if (s1_mode_q) begin
            op_a[p] = {s1_a_sign_q & s1_a_q[p*SUB_W + SUB_W - 1], s1_a_q[p*SUB_W +: SUB_W]};
            op_b[p] = {s1_b_sign_q & s1_b_q[p*SUB_W + SUB_W - 1], s1_b_q[p*SUB_W +: SUB_W]};
         end else begin
            // only the most significant chunk of a signed wide operand carries the sign
            op_a[p] = {s1_a_sign_q & ((p % NA) == NA - 1) & s1_a_q[(p % NA)*SUB_W + SUB_W - 1],
                       s1_a_q[(p % NA)*SUB_W +: SUB_W]};
            op_b[p] = {s1_b_sign_q & ((p / NA) == NB - 1) & s1_b_q[(p / NA)*SUB_W + SUB_W - 1],
                       s1_b_q[(p / NA)*SUB_W +: SUB_W]};
         end
      end
   end

   // signed sub-products: sign-extend both operands to PP_W so the truncated product is exact
   always_comb begin
      pp = '0;
      for (int p = 0; p < NP; p++) begin
         pp[p] = {{(SUB_W + 1){op_a[p][SUB_W]}}, op_a[p]} *
                 {{(SUB_W + 1){op_b[p][SUB_W]}}, op_b[p]};
      end
   end

   // stage 2 next state: register products, bubbles travel as invalid
   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_pp_d    = s2_pp_q;
      s2_mode_d  = s2_mode_q;
`ifdef FRAC_MULT_ACCUM_EN
      s2_acc_d   = s2_acc_q;
`endif
      if (advance) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_pp_d   = pp;
            s2_mode_d = s1_mode_q;
`ifdef FRAC_MULT_ACCUM_EN
            s2_acc_d  = s1_acc_q;
`endif
         end
      end
   end

   // shift-and-add for the wide product, plain per-lane sums for dot products
   always_comb begin
      full_sum = '0;
      lane_sum = '0;
      for (int p = 0; p < NP; p++) begin
         full_sum = full_sum +
                    ({{(LANE_W - PP_W){s2_pp_q[p][PP_W-1]}}, s2_pp_q[p]} << (((p % NA) + (p / NA)) * SUB_W));
         lane_sum[p / NA] = lane_sum[p / NA] +
                            {{(LANE_W - PP_W){s2_pp_q[p][PP_W-1]}}, s2_pp_q[p]};
      end
   end

   // lane selection and optional accumulation against the last delivered result
   always_comb begin
      lane_new  = '0;
      lane_base = '0;
      for (int l = 0; l < NB; l++) begin
         if (s2_mode_q) begin
            lane_new[l] = lane_sum[l];
         end else if (l == 0) begin
            lane_new[l] = full_sum;
         end
`ifdef FRAC_MULT_ACCUM_EN
         if (s2_acc_q && (s2_mode_q || (l == 0))) begin
            lane_base[l] = result_q[l*LANE_W +: LANE_W];
         end
`else
         lane_base[l] = '0;
`endif
      end
   end

   // stage 3 next state: output register holds while the consumer stalls
   always_comb begin
      out_valid_d = out_valid_q;
      result_d    = result_q;
      if (advance) begin
         out_valid_d = s2_valid_q;
         if (s2_valid_q) begin
            for (int l = 0; l < NB; l++) begin
               result_d[l*LANE_W +: LANE_W] = lane_base[l] + lane_new[l];
            end
         end
      end
   end

   // all pipeline state; reset drops every in-flight beat and clears the result
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_a_sign_q <= 1'b0;
         s1_b_sign_q <= 1'b0;
         s1_mode_q   <= 1'b0;
         s2_valid_q  <= 1'b0;
         s2_pp_q     <= '0;
         s2_mode_q   <= 1'b0;
`ifdef FRAC_MULT_ACCUM_EN
         s1_acc_q    <= 1'b0;
         s2_acc_q    <= 1'b0;
`endif
         out_valid_q <= 1'b0;
         result_q    <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_a_sign_q <= s1_a_sign_d;
         s1_b_sign_q <= s1_b_sign_d;
         s1_mode_q   <= s1_mode_d;
         s2_valid_q  <= s2_valid_d;
         s2_pp_q     <= s2_pp_d;
         s2_mode_q   <= s2_mode_d;
`ifdef FRAC_MULT_ACCUM_EN
         s1_acc_q    <= s1_acc_d;
         s2_acc_q    <= s2_acc_d;
`endif
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
      end
   end

endmodule

// File: tb/tb_fracturable_mult_pipe.sv
// tb/tb_fracturable_mult_pipe.sv - self-checking bench for fracturable_mult_pipe
module tb_fracturable_mult_pipe;

   localparam int SUB_W  = 9;
   localparam int NA     = 3;
   localparam int NB     = 2;
   localparam int IN_W   = NA * NB * SUB_W;
   localparam int LANE_W = (NA + NB) * SUB_W;
   localparam int OUT_W  = NB * LANE_W;
   localparam int FA_W   = NA * SUB_W;
   localparam int FB_W   = NB * SUB_W;
`ifdef FRAC_MULT_ACCUM_EN
   localparam bit ACCUM  = 1'b1;
`else
   localparam bit ACCUM  = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [IN_W-1:0]   a;
   logic [IN_W-1:0]   b;
   logic              a_sign;
   logic              b_sign;
   logic              mode;
   logic              acc_in;
   logic              out_valid;
   logic              out_ready;
   logic [OUT_W-1:0]  result;

   int errors = 0;
   int checks = 0;

   logic [OUT_W-1:0]  exp_q[$];
   logic [LANE_W-1:0] model_prev [NB];

   // observations of the most recent step
   bit                s_popped, s_under, s_ov, s_ir, s_acc;
   logic [OUT_W-1:0]  s_got, s_want;

   always #5 clk = ~clk;

   fracturable_mult_pipe #(.SUB_W(SUB_W), .NA(NA), .NB(NB)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .a_sign    (a_sign),
      .b_sign    (b_sign),
      .mode      (mode),
`ifdef FRAC_MULT_ACCUM_EN
      .acc       (acc_in),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic longint as_int(input logic [63:0] raw, input int w, input bit sgn);
      longint v;
      v = longint'(raw & ((64'd1 << w) - 64'd1));
      if (sgn && raw[w-1]) v = v - (longint'(1) << w);
      return v;
   endfunction

   // reference: integer arithmetic straight from the operand definitions
   task automatic model_beat(input logic [IN_W-1:0] av, input logic [IN_W-1:0] bv,
                             input bit as, input bit bs, input bit md, input bit ac);
      logic [LANE_W-1:0] lanes [NB];
      logic [OUT_W-1:0]  packed_r;
      logic [63:0]       bits;
      longint            s;
      int                k;
      for (int l = 0; l < NB; l++) lanes[l] = '0;
      if (!md) begin
         s = as_int(64'(av[FA_W-1:0]), FA_W, as) * as_int(64'(bv[FB_W-1:0]), FB_W, bs);
         bits = s;
         lanes[0] = bits[LANE_W-1:0];
      end else begin
         for (int l = 0; l < NB; l++) begin
            s = 0;
            for (int i = 0; i < NA; i++) begin
               k = l * NA + i;
               s = s + as_int(64'(av[k*SUB_W +: SUB_W]), SUB_W, as) *
                       as_int(64'(bv[k*SUB_W +: SUB_W]), SUB_W, bs);
            end
            bits = s;
            lanes[l] = bits[LANE_W-1:0];
         end
      end
      if (ac && ACCUM) begin
         lanes[0] = lanes[0] + model_prev[0];
         if (md) for (int l = 1; l < NB; l++) lanes[l] = lanes[l] + model_prev[l];
      end
      packed_r = '0;
      for (int l = 0; l < NB; l++) begin
         model_prev[l] = lanes[l];
         packed_r[l*LANE_W +: LANE_W] = lanes[l];
      end
      exp_q.push_back(packed_r);
   endtask

   // one clock: called just after a falling edge with inputs already driven
   task automatic step();
      #1;
      s_ov     = out_valid;
      s_ir     = in_ready;
      s_got    = result;
      s_popped = 1'b0;
      s_under  = 1'b0;
      s_want   = '0;
      s_acc    = in_valid && in_ready;
      if (s_acc) model_beat(a, b, a_sign, b_sign, mode, acc_in);
      if (out_valid && out_ready) begin
         s_popped = 1'b1;
         if (exp_q.size() == 0) s_under = 1'b1;
         else s_want = exp_q.pop_front();
      end
      @(negedge clk);
   endtask

   task automatic clear_model();
      exp_q.delete();
      for (int l = 0; l < NB; l++) model_prev[l] = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; a_sign = 1'b0; b_sign = 1'b0; mode = 1'b0; acc_in = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      clear_model();
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      @(negedge clk);
   endtask

   task automatic test_mode0_directed();
      logic [IN_W-1:0]   va [3];
      logic [IN_W-1:0]   vb [3];
      bit                vs [3];
      logic [LANE_W-1:0] ve [3];
      int                lat;
      logic [OUT_W-1:0]  got;
      // upper operand bits carry junk that full mode must ignore
      va[0] = {27'($urandom()), 27'h7FFFFFF}; vb[0] = {36'($urandom()), 18'h3FFFF}; vs[0] = 1'b0; ve[0] = 45'h1FFFF7FC0001;
      va[1] = {27'($urandom()), 27'h7FFFFFF}; vb[1] = {36'($urandom()), 18'h3FFFF}; vs[1] = 1'b1; ve[1] = 45'h1;
      va[2] = {27'($urandom()), 27'h4000000}; vb[2] = {36'($urandom()), 18'h00001}; vs[2] = 1'b1; ve[2] = 45'h1FFFFC000000;
      for (int v = 0; v < 3; v++) begin
         a = va[v]; b = vb[v]; a_sign = vs[v]; b_sign = vs[v]; mode = 1'b0; acc_in = 1'b0;
         in_valid = 1'b1; out_ready = 1'b1;
         step();
         in_valid = 1'b0;
         lat = 0; got = '0;
         for (int k = 1; k <= 8 && lat == 0; k++) begin
            step();
            if (s_popped) begin lat = k; got = s_got; end
         end
         checks++; if (lat != 3) begin errors++; $display("FAIL mode0_latency[%0d]: got %0d expected 3", v, lat); end
         checks++; if (got[LANE_W-1:0] !== ve[v]) begin errors++; $display("FAIL mode0_lane0[%0d]: got %h expected %h", v, got[LANE_W-1:0], ve[v]); end
         checks++; if (got[OUT_W-1:LANE_W] !== '0) begin errors++; $display("FAIL mode0_lane1[%0d]: got %h expected 0", v, got[OUT_W-1:LANE_W]); end
      end
   endtask

   task automatic test_mode1_directed();
      logic [LANE_W-1:0] ve [2];
      logic [OUT_W-1:0]  got [2];
      int                n;
      ve[0] = 45'h30000;
      ve[1] = 45'h6C000;
      out_ready = 1'b1; mode = 1'b1; acc_in = 1'b0; in_valid = 1'b1;
      a = {(NA*NB){9'h100}}; b = {(NA*NB){9'h100}}; a_sign = 1'b1; b_sign = 1'b1;
      step();
      a = {(NA*NB){9'h180}}; b = {(NA*NB){9'h180}}; a_sign = 1'b0; b_sign = 1'b0;
      step();
      in_valid = 1'b0;
      n = 0; got[0] = '0; got[1] = '0;
      for (int k = 0; k < 10 && n < 2; k++) begin
         step();
         if (s_popped) begin got[n] = s_got; n++; end
      end
      checks++; if (n != 2) begin errors++; $display("FAIL mode1_count: got %0d expected 2", n); end
      for (int v = 0; v < 2; v++) begin
         for (int l = 0; l < NB; l++) begin
            checks++;
            if (got[v][l*LANE_W +: LANE_W] !== ve[v]) begin
               errors++; $display("FAIL mode1_lane[%0d][%0d]: got %h expected %h", v, l, got[v][l*LANE_W +: LANE_W], ve[v]);
            end
         end
      end
   endtask

   task automatic test_random();
      bit               prev_hold;
      logic [OUT_W-1:0] prev_res;
      prev_hold = 1'b0; prev_res = '0;
      for (int c = 0; c < 600; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 3))
            0: a = '1;
            1: a = {(NA*NB){9'h100}};
            default: a = IN_W'({$urandom(), $urandom()});
         endcase
         case ($urandom_range(0, 3))
            0: b = '1;
            1: b = {(NA*NB){9'h100}};
            default: b = IN_W'({$urandom(), $urandom()});
         endcase
         a_sign = 1'($urandom()); b_sign = 1'($urandom());
         mode = 1'($urandom()); acc_in = 1'($urandom());
         step();
         if (prev_hold) begin
            checks++;
            if (s_ov !== 1'b1 || s_got !== prev_res) begin
               errors++; $display("FAIL rand_hold: got valid=%b %h expected valid=1 %h", s_ov, s_got, prev_res);
            end
         end
         if (s_popped) begin
            checks++;
            if (s_under || s_got !== s_want) begin
               errors++; $display("FAIL rand_result: got %h expected %h (spurious=%0b)", s_got, s_want, s_under);
            end
         end
         prev_hold = s_ov && !out_ready;
         prev_res  = s_got;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
         step();
         if (s_popped) begin
            checks++;
            if (s_under || s_got !== s_want) begin
               errors++; $display("FAIL rand_drain: got %h expected %h", s_got, s_want);
            end
         end
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_lost: got %0d outstanding expected 0", exp_q.size()); end
   endtask

   task automatic test_backpressure();
      logic [IN_W-1:0]  ba [6];
      logic [IN_W-1:0]  bb [6];
      logic [2:0]       bf [6];
      logic [OUT_W-1:0] held;
      int               sent, rcvd, hold;
      bit               first;
      for (int i = 0; i < 6; i++) begin
         ba[i] = IN_W'({$urandom(), $urandom()});
         bb[i] = IN_W'({$urandom(), $urandom()});
         bf[i] = 3'($urandom());
      end
      sent = 0; rcvd = 0; hold = 0; first = 1'b0; held = '0; acc_in = 1'b0;
      for (int c = 0; c < 60 && rcvd < 6; c++) begin
         in_valid = (sent < 6);
         if (sent < 6) begin
            a = ba[sent]; b = bb[sent];
            a_sign = bf[sent][0]; b_sign = bf[sent][1]; mode = bf[sent][2];
         end
         out_ready = !(first && hold < 4);
         step();
         if (s_acc) sent++;
         if (!out_ready) begin
            if (hold == 0) held = s_got;
            checks++; if (s_ov !== 1'b1) begin errors++; $display("FAIL bp_valid_hold: got %b expected 1", s_ov); end
            checks++; if (s_ir !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", s_ir); end
            if (hold > 0) begin
               checks++; if (s_got !== held) begin errors++; $display("FAIL bp_stable: got %h expected %h", s_got, held); end
            end
            hold++;
         end
         if (s_popped) begin
            rcvd++;
            first = 1'b1;
            checks++;
            if (s_under || s_got !== s_want) begin
               errors++; $display("FAIL bp_result: got %h expected %h", s_got, s_want);
            end
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         checks++; if (s_popped) begin errors++; $display("FAIL bp_duplicate: got extra result %h expected none", s_got); end
      end
      checks++; if (rcvd != 6 || sent != 6) begin errors++; $display("FAIL bp_count: got sent=%0d rcvd=%0d expected 6/6", sent, rcvd); end
   endtask

   task automatic test_reset_midstream();
      int lat;
      out_ready = 1'b1; in_valid = 1'b1; acc_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a = IN_W'({$urandom(), $urandom()}); b = IN_W'({$urandom(), $urandom()});
         a_sign = 1'($urandom()); b_sign = 1'($urandom()); mode = 1'($urandom());
         step();
      end
      in_valid = 1'b0; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      clear_model();
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b expected 0", out_valid); end
      checks++; if (result !== '0) begin errors++; $display("FAIL mid_reset_result: got %h expected 0", result); end
      @(negedge clk);
      a = IN_W'({$urandom(), $urandom()}); b = IN_W'({$urandom(), $urandom()});
      a_sign = 1'b1; b_sign = 1'b0; mode = 1'b1; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      lat = 0;
      for (int k = 1; k <= 8; k++) begin
         step();
         if (s_popped) begin
            if (lat == 0) lat = k;
            checks++;
            if (s_under || s_got !== s_want) begin
               errors++; $display("FAIL mid_after_result: got %h expected %h", s_got, s_want);
            end
         end
      end
      checks++; if (lat != 3) begin errors++; $display("FAIL mid_after_latency: got %0d expected 3", lat); end
   endtask

`ifdef FRAC_MULT_ACCUM_EN
   task automatic test_accum();
      bit               seq [4];
      logic [LANE_W-1:0] ve [4];
      logic [OUT_W-1:0] got [4];
      int               n;
      seq[0] = 1'b0; seq[1] = 1'b1; seq[2] = 1'b1; seq[3] = 1'b0;
      ve[0] = 45'd3; ve[1] = 45'd6; ve[2] = 45'd9; ve[3] = 45'd3;
      a = {(NA*NB){9'h001}}; b = {(NA*NB){9'h001}};
      a_sign = 1'b0; b_sign = 1'b0; mode = 1'b1; out_ready = 1'b1;
      n = 0;
      for (int i = 0; i < 4; i++) got[i] = '0;
      for (int c = 0; c < 12 && n < 4; c++) begin
         in_valid = (c < 4);
         acc_in   = (c < 4) ? seq[c] : 1'b0;
         step();
         if (s_popped) begin got[n] = s_got; n++; end
      end
      in_valid = 1'b0;
      checks++; if (n != 4) begin errors++; $display("FAIL accum_count: got %0d expected 4", n); end
      for (int v = 0; v < 4; v++) begin
         for (int l = 0; l < NB; l++) begin
            checks++;
            if (got[v][l*LANE_W +: LANE_W] !== ve[v]) begin
               errors++; $display("FAIL accum_lane[%0d][%0d]: got %0d expected %0d", v, l, got[v][l*LANE_W +: LANE_W], ve[v]);
            end
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_mode0_directed();
      test_mode1_directed();
`ifdef FRAC_MULT_ACCUM_EN
      test_accum();
`endif
      test_backpressure();
      test_random();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
